// File: rtl/tick_counter.sv
// Loadable free-running byte counter with gated output bus and wrap pulse.
// Define COUNTER_WRAP_HALT_EN to make a wrap saturate at all-ones and enter HALT.
module tick_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic             out_en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             halted
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    localparam logic [WIDTH-1:0] AllOnes = '1;
    localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_val;
            state_d = StRun;
        end else if (inc && (state_q == StRun)) begin
            if (count_q == AllOnes) begin
                wrap_d = 1'b1;
`ifdef COUNTER_WRAP_HALT_EN
                // Saturate: count holds at all-ones until load or rst.
                state_d = StHalt;
`else
                count_d = '0;
`endif
            end else begin
                count_d = count_q + One;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign out   = out_en ? count_q : '0;
    assign wrap  = wrap_q;

`ifdef COUNTER_WRAP_HALT_EN
    assign halted = (state_q == StHalt);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_tick_counter.sv
// Self-checking bench for tick_counter: directed cases then randomized traffic
// against an arithmetic reference model; honours COUNTER_WRAP_HALT_EN.
module tb_tick_counter;

    localparam int W   = 8;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst, load, inc, out_en;
    logic [W-1:0] load_val;
    logic [W-1:0] count, out;
    logic         wrap, halted;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_cnt;
    bit m_wrap;
    bit m_halt;

`ifdef COUNTER_WRAP_HALT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    tick_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .inc      (inc),
        .out_en   (out_en),
        .count    (count),
        .out      (out),
        .wrap     (wrap),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the currently applied inputs.
    task automatic model_edge();
        if (rst) begin
            m_cnt = 0; m_wrap = 0; m_halt = 0;
        end else if (load) begin
            m_cnt = int'(load_val); m_wrap = 0; m_halt = 0;
        end else if (inc && !m_halt) begin
            if (m_cnt + 1 == MOD) begin
                m_wrap = 1;
                if (HaltEn) m_halt = 1;
                else m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
                m_wrap = 0;
            end
        end else begin
            m_wrap = 0;
        end
    endtask

    task automatic check_all();
        check_eq("count", count, m_cnt);
        check_eq("out", out, out_en ? m_cnt : 0);
        check_eq("wrap", wrap, m_wrap);
        check_eq("halted", halted, m_halt);
    endtask

    task automatic step(input bit r, input bit l, input logic [W-1:0] lv, input bit i,
                        input bit oe);
        rst = r; load = l; load_val = lv; inc = i; out_en = oe;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1; load = 0; load_val = '0; inc = 0; out_en = 1;
        m_cnt = 0; m_wrap = 0; m_halt = 0;

        // Reset values and first counts
        step(1, 0, 8'h00, 0, 1);
        check_eq("reset_count", count, 0);
        check_eq("reset_out", out, 0);
        repeat (3) step(0, 0, 8'h00, 1, 1);
        check_eq("inc3_count", count, 3);

        // Wrap from 0xFE
        step(0, 1, 8'hFE, 0, 1);
        check_eq("load_fe", count, 8'hFE);
        step(0, 0, 8'h00, 1, 1);
        check_eq("step_ff", count, 8'hFF);
        step(0, 0, 8'h00, 1, 1);
        check_eq("wrap_pulse", wrap, 1);
        check_eq("post_wrap", count, HaltEn ? 8'hFF : 8'h00);
        repeat (2) step(0, 0, 8'h00, 1, 1);
        check_eq("wrap_once", wrap, 0);
        check_eq("halt_sticky", halted, HaltEn);
        step(0, 1, 8'h10, 0, 1);
        check_eq("load_exit", count, 8'h10);
        check_eq("load_unhalt", halted, 0);

        // Priority
        step(0, 1, 8'h42, 1, 1);
        check_eq("load_over_inc", count, 8'h42);
        step(1, 1, 8'h99, 1, 1);
        check_eq("rst_over_load", count, 0);

        // Combinational output enable
        step(0, 1, 8'h5A, 0, 1);
        out_en = 1; #1; check_eq("oe1", out, 8'h5A);
        out_en = 0; #1; check_eq("oe0", out, 8'h00);
        out_en = 1; #1; check_eq("oe1b", out, 8'h5A);
        check_eq("oe_count", count, 8'h5A);

        // Reset mid-count with inc held
        step(0, 1, 8'h36, 0, 1);
        step(0, 0, 8'h00, 1, 1);
        check_eq("at_37", count, 8'h37);
        step(1, 0, 8'h00, 1, 1);
        check_eq("rst_mid", count, 0);
        step(0, 0, 8'h00, 1, 1);
        check_eq("after_rst", count, 1);

        // Randomized traffic, biased toward loads near all-ones
        for (int k = 0; k < 3000; k++) begin
            logic [W-1:0] lv;
            lv = ($urandom_range(0, 1) == 0) ? W'($urandom_range(8'hF0, 8'hFF))
                                             : W'($urandom);
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), lv,
                 ($urandom_range(0, 3) != 0), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
